bound_flasher_lamp_path: RTL and testbench

- Datapath and input-conditioning end of the bound flasher.
- Executes the controller's enable/upcount commands on a saturating lamp counter and returns counter_val to the controller.
- Drives a thermometer-coded lamp bar.
- Delivers a synchronised, debounced flick level to the controller.

---
 rtl/bound_flasher_lamp_path_pkg.sv | 31 +++
 rtl/bound_flasher_lamp_path_if.sv | 28 ++
 rtl/bound_flasher_lamp_path_flick_debouncer.sv | 45 ++++
 rtl/bound_flasher_lamp_path.sv | 74 +++++++
 tb/tb_bound_flasher_lamp_path.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bound_flasher_lamp_path_pkg.sv
// Shared bound flasher definitions: lamp bar geometry, controller turn points
// and the thermometer decode used by both the controller and the lamp path.
package bound_flasher_pkg;

    localparam int LAMP_COUNT_DEF = 16;
    localparam int CNT_W_DEF      = 5;
    localparam int THERM_MAX      = 64;

    localparam logic [CNT_W_DEF-1:0] TP_ZERO = 5'd0;
    localparam logic [CNT_W_DEF-1:0] TP_ONE  = 5'd1;
    localparam logic [CNT_W_DEF-1:0] TP_FIVE = 5'd5;
    localparam logic [CNT_W_DEF-1:0] TP_TEN  = 5'd10;
    localparam logic [CNT_W_DEF-1:0] TP_FULL = 5'd16;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2
    } step_cmd_e;

    // Lamp i is lit iff i < count; callers cast the result to their bar width.
    function automatic logic [THERM_MAX-1:0] therm_decode(input int unsigned count);
        logic [THERM_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            v[i] = (i < count);
        end
        return v;
    endfunction

endpackage

// File: rtl/bound_flasher_lamp_path_if.sv
// Command/status bundle between the bound flasher controller (master)
// and the lamp path (slave); flick_raw comes from the pushbutton side.
interface bound_flasher_lamp_path_if
    import bound_flasher_pkg::*;
#(
    parameter int LAMP_COUNT = LAMP_COUNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
);

    logic                  flick_raw;
    logic                  enable;
    logic                  upcount;
    logic [CNT_W-1:0]      counter_val;
    logic [LAMP_COUNT-1:0] lamps;
    logic                  flick;
    logic                  bound_err;

    modport master (
        output flick_raw, enable, upcount,
        input  counter_val, lamps, flick, bound_err
    );

    modport slave (
        input  flick_raw, enable, upcount,
        output counter_val, lamps, flick, bound_err
    );

endinterface

// File: rtl/bound_flasher_lamp_path_flick_debouncer.sv
// Two-flop synchroniser plus debounce counter; flick only follows the button
// after DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module flick_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flick_raw,
    output logic flick
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("flick_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // the synchroniser flops are reset too so no stale level survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            flick  <= 1'b0;
        end else begin
            s1 <= flick_raw;
            s2 <= s1;
            if (s2 == flick) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                flick  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/bound_flasher_lamp_path.sv
// Lamp path of the bound flasher: saturating lamp counter driven by the
// controller, registered thermometer lamp bar and debounced flick input.
module bound_flasher_lamp_path
    import bound_flasher_pkg::*;
#(
    parameter int LAMP_COUNT      = LAMP_COUNT_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                     clk,
    input logic                     reset,
    bound_flasher_lamp_path_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAMP_COUNT);

    step_cmd_e             cmd;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic [LAMP_COUNT-1:0] lamps_q;
    logic [LAMP_COUNT-1:0] lamps_nxt;
    logic                  bound_hit;
    logic                  bound_err_q;

    if ((1 << CNT_W) <= LAMP_COUNT || LAMP_COUNT > THERM_MAX) begin : g_bad_cfg
        $error("bound_flasher_lamp_path: CNT_W too narrow or LAMP_COUNT too large");
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cmd       = !bus.enable ? CMD_HOLD : (bus.upcount ? CMD_UP : CMD_DOWN);
        count_nxt = count_q;
        bound_hit = 1'b0;
        unique case (cmd)
            CMD_UP: begin
                if (count_q == CNT_MAX) bound_hit = 1'b1;
                else                    count_nxt = count_q + CNT_W'(1);
            end
            CMD_DOWN: begin
                if (count_q == '0) bound_hit = 1'b1;
                else               count_nxt = count_q - CNT_W'(1);
            end
            default: ;
        endcase
        // Decoding the next count keeps lamps and counter_val skew-free.
        lamps_nxt = LAMP_COUNT'(therm_decode(32'(count_nxt)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            lamps_q     <= '0;
            bound_err_q <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            lamps_q     <= lamps_nxt;
            bound_err_q <= bound_hit;
        end
    end

    flick_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_flick_debouncer (
        .clk      (clk),
        .reset    (reset),
        .flick_raw(bus.flick_raw),
        .flick    (bus.flick)
    );

    assign bus.counter_val = count_q;
    assign bus.lamps       = lamps_q;
    assign bus.bound_err   = bound_err_q;

endmodule

// File: tb/tb_bound_flasher_lamp_path.sv
// Scoreboard bench for the bound flasher lamp path: directed sweeps, debounce
// patterns and random traffic checked against a window-based reference model.
module tb_bound_flasher_lamp_path;

    localparam int L = 16;
    localparam int W = 5;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bound_flasher_lamp_path_if #(.LAMP_COUNT(L), .CNT_W(W)) bus ();

    bound_flasher_lamp_path #(
        .LAMP_COUNT     (L),
        .CNT_W          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cnt;
        logic [L-1:0] lamps;
        bit           berr;
        bit           flick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: lamp count, debounced level, raw button history.
    int   m_cnt;
    bit   m_flick;
    bit   raw_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_counter_val"}, 32'(bus.counter_val), 32'd0);
        check({tag, "_lamps"},       32'(bus.lamps),       32'd0);
        check({tag, "_flick"},       32'(bus.flick),       32'd0);
        check({tag, "_bound_err"},   32'(bus.bound_err),   32'd0);
    endtask

    function automatic void model_reset();
        m_cnt   = 0;
        m_flick = 1'b0;
        raw_hist.delete();
        for (int i = 0; i < D + 2; i++) raw_hist.push_back(1'b0);
    endfunction

    // Expected outputs after the edge that samples (en, up, raw).
    function automatic void model_step(input bit en, input bit up, input bit raw);
        exp_t e;
        bit   all_flip;
        e.berr = en && (up ? (m_cnt == L) : (m_cnt == 0));
        if (en && !e.berr) m_cnt = m_cnt + (up ? 1 : -1);
        raw_hist.push_back(raw);
        // The debouncer sees the raw level from two edges back; flick flips once
        // the last D such samples all disagree with it.
        all_flip = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (raw_hist[raw_hist.size() - 3 - i] == m_flick) all_flip = 1'b0;
        end
        if (all_flip) m_flick = !m_flick;
        while (raw_hist.size() > D + 3) void'(raw_hist.pop_front());
        e.cnt   = m_cnt;
        e.lamps = L'((33'd1 << m_cnt) - 33'd1);
        e.flick = m_flick;
        sb.push_back(e);
    endfunction

    task automatic drive(input bit en, input bit up, input bit raw);
        @(negedge clk);
        bus.enable    = en;
        bus.upcount   = up;
        bus.flick_raw = raw;
        model_step(en, up, raw);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.upcount   = 1'b0;
        bus.flick_raw = 1'b0;
        model_reset();
        model_step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every post-edge output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && sb.size() > 0) begin
                e = sb.pop_front();
                check("counter_val", 32'(bus.counter_val), 32'(e.cnt));
                check("lamps",       32'(bus.lamps),       32'(e.lamps));
                check("bound_err",   32'(bus.bound_err),   32'(e.berr));
                check("flick",       32'(bus.flick),       32'(e.flick));
            end
        end
    end

    initial begin
        bit raw_r;
        bit en_r;
        bit up_r;
        int bias;
        int guard;
        bit pat[10];

        bus.enable    = 1'b0;
        bus.upcount   = 1'b0;
        bus.flick_raw = 1'b0;
        model_reset();

        #1 reset = 1'b1;
        #1 check_zero("por");
        repeat (2) @(posedge clk);
        release_reset();

        // Count to 7 with the button held so flick is set before the reset.
        repeat (7) drive(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        bus.flick_raw = 1'b0;
        bus.enable    = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        release_reset();

        // Sweep up to the top, then one step past it.
        repeat (5)  drive(1'b1, 1'b1, 1'b0);
        repeat (11) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Sweep down to the floor, then one step past it.
        repeat (16) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Hold at 9 with upcount toggling.
        repeat (9) drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, i[0], 1'b0);

        // Debounce: short glitch, held press, release.
        repeat (3)  drive(1'b0, 1'b0, 1'b1);
        repeat (8)  drive(1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 1'b0);

        // Bouncing button while alternating up/down around 10.
        drive(1'b1, 1'b1, 1'b0);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) drive(1'b1, (i % 2) == 0, pat[i]);
        repeat (8) drive(1'b0, 1'b0, 1'b0);

        // Random traffic with a drifting up/down bias so both bounds get hit.
        raw_r = 1'b0;
        bias  = 8;
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) bias = (bias == 8) ? 2 : 8;
            if ($urandom_range(0, 5) == 0) raw_r = !raw_r;
            en_r = ($urandom_range(0, 3) != 0);
            up_r = ($urandom_range(0, 9) < bias);
            drive(en_r, up_r, raw_r);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
